alu_op_sequencer: RTL

//  Initiator side of the ALU operand/result interface: accepts one operation (a, b, opcode, Cin) over a

---
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation per valid/ready request, waits SETTLE_CYCLES, then offers the captured result.
// Optional feature: define ALU_SEQ_ERR_EN to reject opcodes 10..15 with an err indication.
module alu_op_sequencer #(
  parameter int N             = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_op,
  input  logic         in_cin,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  output logic         alu_cin,
  input  logic [N-1:0] alu_result,
  input  logic         alu_neg,
  input  logic         alu_zero,
  input  logic         alu_cout,
  input  logic         alu_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         busy,
  output logic [7:0]   op_count,
  output logic         err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]   sel_q, sel_d, flags_q, flags_d;
  logic         cin_q, cin_d;
  logic [7:0]   count_q, count_d;
  logic         opInvalid;
  logic         errActive;

`ifdef ALU_SEQ_ERR_EN
  logic err_q, err_d;
  assign opInvalid = (in_op > 4'd9);
  assign errActive = err_q;
`else
  assign opInvalid = 1'b0;
  assign errActive = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      count_q <= '0;
`ifdef ALU_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      count_q <= count_d;
`ifdef ALU_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // A rejected opcode still spends one WAIT slot with the counter at zero, so its result
  // appears with the same one-cycle latency as the shortest normal operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cin_d   = cin_q;
    res_d   = res_q;
    flags_d = flags_q;
    count_d = count_q;
`ifdef ALU_SEQ_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = WAIT;
          if (opInvalid) begin
            cnt_d = '0;
`ifdef ALU_SEQ_ERR_EN
            err_d = 1'b1;
`endif
          end else begin
            a_d   = in_a;
            b_d   = in_b;
            sel_d = in_op;
            cin_d = in_cin;
            cnt_d = SettleLoad;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (errActive) begin
            res_d   = '0;
            flags_d = '0;
          end else begin
            res_d   = alu_result;
            flags_d = {alu_neg, alu_zero, alu_cout, alu_ovf};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (!errActive) count_d = count_q + 8'd1;
`ifdef ALU_SEQ_ERR_EN
          err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign alu_cin    = cin_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign op_count   = count_q;
  assign err        = errActive;

endmodule
